// File: rtl/common.sv
// Shared types and default latencies for the execute-stage sequencer.
package common;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } ex_seq_state_t;

    typedef enum logic [1:0] {
        EX_ALU = 2'd0,
        EX_MUL = 2'd1,
        EX_DIV = 2'd2,
        EX_RSV = 2'd3
    } ex_class_t;

    localparam int unsigned EX_MUL_CYCLES = 4;
    localparam int unsigned EX_DIV_CYCLES = 32;

endpackage

// File: rtl/execute_stage_seq_counter.sv
// Loadable down-counter with zero flag and synchronous clear; saturates at zero.
module ex_seq_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/execute_stage_seq.sv
// Execute-stage sequencer: admits one op at a time, sequences MUL/DIV, holds result for writeback.
// Define EXECUTE_STAGE_SEQ_DIV_EN to sequence DIV on the iterative unit; otherwise DIV is illegal.
module execute_stage_seq
    import common::*;
#(
    parameter int unsigned MUL_CYCLES = EX_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = EX_DIV_CYCLES,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [1:0] issue_class,
    input  logic       flush,
    output logic       unit_start,
    output logic       unit_sel,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [1:0] res_class,
    output logic       illegal_op,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    ex_seq_state_t    state_q;
    logic             res_valid_q;
    logic [1:0]       res_class_q;
    logic             illegal_q;
    logic             accept;
    logic             is_multi;
    logic             is_illegal;
    logic             cnt_zero;
    logic [CNT_W-1:0] load_val;

    always_comb begin
`ifdef EXECUTE_STAGE_SEQ_DIV_EN
        is_multi   = (issue_class == EX_MUL) || (issue_class == EX_DIV);
        is_illegal = (issue_class == EX_RSV);
        unit_sel   = (issue_class == EX_DIV);
`else
        is_multi   = (issue_class == EX_MUL);
        is_illegal = (issue_class == EX_RSV) || (issue_class == EX_DIV);
        unit_sel   = 1'b0;
`endif
        load_val    = (issue_class == EX_DIV) ? DIV_LOAD : MUL_LOAD;
        issue_ready = !rst && !flush &&
                      ((state_q == IDLE) || ((state_q == HOLD) && res_ready));
        accept      = issue_valid && issue_ready && !flush;
        unit_start  = accept && is_multi;
    end

    ex_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (unit_start),
        .load_val (load_val),
        .dec      (state_q == EXEC),
        .zero     (cnt_zero)
    );

    // Flush beats accept beats the per-state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            res_class_q <= 2'd0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
        end else if (accept) begin
            res_class_q <= issue_class;
            illegal_q   <= is_illegal;
            if (is_multi) begin
                state_q     <= EXEC;
                res_valid_q <= 1'b0;
            end else begin
                state_q     <= HOLD;
                res_valid_q <= 1'b1;
            end
        end else begin
            unique case (state_q)
                EXEC: begin
                    if (cnt_zero) begin
                        state_q     <= HOLD;
                        res_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign illegal_op = illegal_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/execute_stage_seq.md
# execute_stage_seq

Execute-stage sequencer. It sits between decode issue and the execute datapath and admits one operation at a time. Single-cycle ALU ops pass through with one cycle of latency. Multi-cycle MUL/DIV ops start the iterative unit and stall issue until the op completes. The result is held until writeback accepts it, and a branch flush kills whatever is in flight.

## Interface
Parameters:
- MUL_CYCLES, 4, total MUL latency from acceptance to res_valid; legal range 2..255
- DIV_CYCLES, 32, total DIV latency from acceptance to res_valid; legal range 2..255
- CNT_W, 8, width of the countdown counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode presents an op
- issue_ready  out  1  sequencer accepts the op this cycle
- issue_class  in  2  0=single-cycle ALU, 1=MUL, 2=DIV, 3=reserved
- flush  in  1  kill in-flight op (taken branch/jump)
- unit_start  out  1  one-cycle start pulse to MUL/DIV unit
- unit_sel  out  1  0=MUL, 1=DIV; valid when unit_start=1
- res_valid  out  1  execute result is available
- res_ready  in  1  writeback consumes the result
- res_class  out  2  class of the held result
- illegal_op  out  1  held result came from a reserved class; qualified by res_valid
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, HOLD. Encoding lives in the package.
- Accept condition: accept = issue_valid && issue_ready && !flush.
- issue_ready = !rst && !flush && (state==IDLE || (state==HOLD && res_ready)).
- issue_ready is never asserted in EXEC.
- On accept of class 0 or 3: next state HOLD. res_class is latched. illegal_op is latched to (class==3).
- On accept of class 1 or 2:
  - unit_start=1 combinationally in the accept cycle; unit_sel = (class==2).
  - Counter is loaded with LAT-2, where LAT is MUL_CYCLES or DIV_CYCLES.
  - Next state EXEC.
- EXEC: counter decrements each cycle. When counter==0, next state is HOLD.
- HOLD:
  - res_valid=1.
  - If res_ready without accept, next state IDLE.
  - If res_ready with accept, take the accept transition (back-to-back issue, no bubble).
  - If !res_ready, stay in HOLD; res_class and illegal_op are held stable.
- Flush has top priority in every state:
  - Next state IDLE, counter cleared to 0.
  - unit_start and issue_ready are forced 0 in the flush cycle.
  - A result pending in HOLD is discarded.
- Counter arithmetic: unsigned CNT_W bits; never decrements below 0.

## Timing
- Reset values: state=IDLE, counter=0, res_valid=0, res_class=0, illegal_op=0, unit_start=0, busy=0, issue_ready=0 while rst is high.
- issue_ready rises combinationally once rst is low and state is IDLE.
- Class 0 accepted in cycle N: res_valid=1 in cycle N+1.
- MUL accepted in cycle N: unit_start in cycle N; res_valid=1 in cycle N+MUL_CYCLES. Same for DIV with DIV_CYCLES.
- Sustained single-cycle throughput: one op per cycle while res_ready=1.
- Flush in cycle N: res_valid=0 and busy=0 in cycle N+1; a new issue can be accepted in cycle N+1.
- Reset asserted mid-EXEC or mid-HOLD: outputs return to reset values immediately, no clock edge needed.

## Configuration
- EXECUTE_STAGE_SEQ_DIV_EN defined: DIV (class 2) is sequenced as above.
- EXECUTE_STAGE_SEQ_DIV_EN undefined:
  - Class 2 takes the single-cycle path with illegal_op=1.
  - unit_sel is tied to 0; unit_start never fires for class 2.
  - DIV_CYCLES is ignored.

## Structure
- Shared package `common` holds:
  - ex_seq_state_t enum (IDLE, EXEC, HOLD)
  - ex_class_t enum (EX_ALU, EX_MUL, EX_DIV, EX_RSV)
  - default latency constants EX_MUL_CYCLES=4 and EX_DIV_CYCLES=32
- One sub-module: ex_seq_counter (loadable down-counter with zero flag and synchronous clear), instantiated once.
- Top level contains only the FSM and the output registers.

## Test plan
- Reset release, class 0 issued with res_ready=1 -> issue_ready=1 on the first cycle after reset; res_valid at N+1 with res_class=0, illegal_op=0.
- MUL with MUL_CYCLES=4 accepted at N -> unit_start=1, unit_sel=0 at N; issue_ready=0 during N+1..N+3; res_valid at N+4.
- DIV accepted, res_ready held 0 for 5 cycles after res_valid -> res_valid and res_class=2 stay stable; issue_ready=0 until res_ready rises; back-to-back ALU accepted in the same cycle.
- Flush asserted 10 cycles into a DIV -> unit_start stays 0; busy=0 and res_valid=0 next cycle; a following ALU op completes in 1 cycle.
- Class 3 issued -> res_valid with illegal_op=1. With EXECUTE_STAGE_SEQ_DIV_EN undefined, class 2 -> res_valid at N+1 with illegal_op=1 and no unit_start.
- rst asserted asynchronously mid-EXEC -> res_valid, busy and issue_ready drop to 0 without a clock edge; first op after release behaves normally.
